bist_response_analyzer: RTL and testbench
=========================================

# bist_response_analyzer

Response-side counterpart of the BIST controller. It consumes the controller's `init`/`running`/`finish` strobes together with the circuit-under-test response word, and compresses the responses into a MISR signature. At the end of a run it compares the signature and the compressed-cycle count against golden values and reports pass/fail. It also flags any strobe sequence that violates the controller protocol.

## Interface
- `WIDTH`, 8, response and signature width
- `POLY`, 8'h1D, MISR feedback polynomial (x^8+x^4+x^3+x^2+1), WIDTH bits
- `SEED`, 8'h00, signature value loaded on `init`
- `GOLDEN`, 8'h1D, expected final signature
- `EXP_CYCLES`, 5, expected number of compressed cycles
- `CNT_W`, 4, width of the cycle counter
- `clk`  in  1  single clock, all logic on rising edge
- `reset`  in  1  synchronous, active-high
- `start`  in  1  run restart, same meaning as at the controller; synchronous clear to IDLE
- `init`  in  1  controller INIT strobe
- `running`  in  1  controller RUNNING qualifier; response valid this cycle
- `finish`  in  1  controller FINISH strobe
- `data_in`  in  WIDTH  CUT response word
- `signature`  out  WIDTH  current MISR contents
- `count`  out  CNT_W  responses compressed this run
- `done`  out  1  result valid
- `pass`  out  1  signature==GOLDEN and count==EXP_CYCLES
- `fail`  out  1  complement of pass while done
- `proto_err`  out  1  sticky protocol violation

## Operation
- Registered outputs. Reset or `start` sets: state IDLE, `signature`=SEED, `count`=0, and `done`/`pass`/`fail`/`proto_err`=0. `reset` and `start` have identical effect and take priority over everything else.
- MISR step: sig' = {sig[WIDTH-2:0],1'b0} ^ (sig[WIDTH-1] ? POLY : 0) ^ data_in.
- State machine:
  - IDLE
    - `init` → ARMED, loading SEED and clearing `count`.
    - `running` or `finish` → sets `proto_err`; state stays IDLE.
  - ARMED
    - `running` → COMPRESS; absorbs `data_in` this cycle and increments `count`.
    - `finish` → CHECK.
    - Otherwise hold.
  - COMPRESS
    - `running` → absorb and increment; `count` saturates at 2^CNT_W−1.
    - Neither strobe → hold; gaps are legal.
    - `finish` → CHECK.
  - CHECK (one cycle): registers `pass`/`fail`, sets `done` → DONE.
  - DONE
    - Results hold.
    - `init` → ARMED, clearing `done`/`pass`/`fail`; `proto_err` is kept.
    - `running` or `finish` → sets `proto_err`; no state change.
- Simultaneous events:
  - `init` with `running` or `finish`: `init` wins and `proto_err` is set.
  - `running` with `finish` in ARMED or COMPRESS: `finish` wins, no absorb, and `proto_err` is set.
  - `init` in ARMED, COMPRESS or CHECK: reloads SEED, goes to ARMED, and sets `proto_err`.
- `pass` and `fail` are never both 1. Both are 0 whenever `done`=0.

## Timing
- Absorb: `running` high in cycle k → `signature`/`count` updated in cycle k+1.
- `finish` high in cycle k → state CHECK in cycle k+1 → `done`/`pass`/`fail` valid from cycle k+2 until `start`, `reset` or `init`.
- `proto_err` rises the cycle after the offending cycle.
- No combinational path from inputs to outputs.

## Structure
- Shared package `bist_pkg` holds:
  - the state enum (IDLE, ARMED, COMPRESS, CHECK, DONE);
  - default POLY/SEED constants, shared with any pattern-generator LFSR.
- Sub-module `bist_misr`: WIDTH/POLY/SEED parameters, with inputs `load` and `en`, input `d`, output `q`. It holds the signature register only.
- FSM, counter and compare logic live in the top module.

## Test plan
- Reset: assert `reset` 2 cycles → `signature`=0x00, `count`=0, and `done`/`pass`/`fail`/`proto_err`=0.
- Pass (GOLDEN=0x1D, EXP_CYCLES=2): `init`, then `running` with data 0x80 then 0x00, then `finish` → `signature` 0x80 then 0x1D; `count`=2; `done`=`pass`=1 two cycles after `finish`.
- Signature fail (same parameters): data 0x80 then 0x01 → `signature`=0x1C; `fail`=1, `pass`=0.
- Count fail (GOLDEN=0x00, EXP_CYCLES=2): 3 `running` cycles with data 0x00 → `signature`=0x00, `count`=3; `fail`=1.
- Protocol error: `running` while IDLE → `proto_err`=1 next cycle, `signature` unchanged; `start` pulse → `proto_err`=0.
- Reset mid-run: `reset` during COMPRESS after 2 absorbs → next cycle `count`=0 and `signature`=SEED. A following `finish` → `proto_err`=1 and `done` stays 0.

Source files
------------

// File: rtl/bist_pkg.sv
// Shared BIST definitions.
// Purpose : state encoding for the response analyzer FSM and the default
//           MISR/LFSR polynomial and seed shared with the pattern generator.
// Ports   : none (package).
package bist_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ARMED    = 3'd1,
    ST_COMPRESS = 3'd2,
    ST_CHECK    = 3'd3,
    ST_DONE     = 3'd4
  } bist_state_e;

  // x^8 + x^4 + x^3 + x^2 + 1, implicit x^8 term dropped.
  localparam logic [7:0] DEF_POLY = 8'h1D;
  localparam logic [7:0] DEF_SEED = 8'h00;

endpackage

// File: rtl/bist_response_analyzer_if.sv
// Response analyzer bus.
// Purpose : bundles the controller strobes, the CUT response word and the
//           analyzer results/debug state.
// Ports   : master drives start/init/running/finish/data_in and observes
//           signature/count/done/pass/fail/proto_err/state; slave is the
//           analyzer side.
// Handshake: there is no back-pressure. init, finish and start are
// single-cycle strobes; running is a per-cycle qualifier meaning data_in is
// valid and must be absorbed in that cycle. Results are valid while done=1.
interface bist_response_analyzer_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
);
  import bist_pkg::*;

  logic             start;
  logic             init;
  logic             running;
  logic             finish;
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] signature;
  logic [CNT_W-1:0] count;
  logic             done;
  logic             pass;
  logic             fail;
  logic             proto_err;
  bist_state_e      state;

  modport master (
    output start, init, running, finish, data_in,
    input  signature, count, done, pass, fail, proto_err, state
  );

  modport slave (
    input  start, init, running, finish, data_in,
    output signature, count, done, pass, fail, proto_err, state
  );

endinterface

// File: rtl/bist_misr.sv
// Multiple-input signature register.
// Purpose : holds the signature; load reloads SEED, en absorbs d.
// Ports   : clk, load (SEED reload, wins over en), en (absorb d this cycle),
//           d (response word), q (current signature).
module bist_misr import bist_pkg::*; #(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] POLY  = DEF_POLY,
  parameter logic [WIDTH-1:0] SEED  = DEF_SEED
) (
  input  logic             clk,
  input  logic             load,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (load) begin
      q <= SEED;
    end else if (en) begin
      q <= {q[WIDTH-2:0], 1'b0} ^ (q[WIDTH-1] ? POLY : '0) ^ d;
    end
  end

endmodule

// File: rtl/bist_response_analyzer.sv
// BIST response analyzer.
// Purpose : compresses CUT responses into a MISR signature under control of
//           the BIST controller strobes, compares signature and cycle count
//           with golden values at the end of a run and flags strobe
//           sequences that break the controller protocol.
// Ports   : clk, reset (synchronous, active-high), bus (slave modport):
//           start/init/running/finish/data_in in; signature, count, done,
//           pass, fail, proto_err and debug state out. All outputs are
//           registered.
module bist_response_analyzer import bist_pkg::*; #(
  parameter int               WIDTH      = 8,
  parameter logic [WIDTH-1:0] POLY       = DEF_POLY,
  parameter logic [WIDTH-1:0] SEED       = DEF_SEED,
  parameter logic [WIDTH-1:0] GOLDEN     = 8'h1D,
  parameter int               EXP_CYCLES = 5,
  parameter int               CNT_W      = 4
) (
  input logic                     clk,
  input logic                     reset,
  bist_response_analyzer_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_EXP = CNT_W'(EXP_CYCLES);

  bist_state_e      state_q;
  logic [CNT_W-1:0] count_q;
  logic             done_q;
  logic             pass_q;
  logic             fail_q;
  logic             proto_err_q;
  logic [WIDTH-1:0] sig_q;

  logic clr;
  logic any_run;
  logic in_run;
  logic misr_load;
  logic misr_en;
  logic match;

  assign clr     = reset | bus.start;
  assign any_run = bus.running | bus.finish;
  assign in_run  = (state_q == ST_ARMED) || (state_q == ST_COMPRESS);

  // init always reloads the seed, whatever state it arrives in. An absorb
  // needs running without a competing init/finish, which both win.
  assign misr_load = clr | bus.init;
  assign misr_en   = !misr_load && in_run && bus.running && !bus.finish;

  assign match = (sig_q == GOLDEN) && (count_q == CNT_EXP);

  bist_misr #(
    .WIDTH (WIDTH),
    .POLY  (POLY),
    .SEED  (SEED)
  ) u_misr (
    .clk  (clk),
    .load (misr_load),
    .en   (misr_en),
    .d    (bus.data_in),
    .q    (sig_q)
  );

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q     <= ST_IDLE;
      count_q     <= '0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      fail_q      <= 1'b0;
      proto_err_q <= 1'b0;
    end else if (bus.init) begin
      state_q <= ST_ARMED;
      count_q <= '0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      fail_q  <= 1'b0;
      // init is only legal from IDLE or DONE and never with another strobe.
      if (any_run || in_run || (state_q == ST_CHECK)) begin
        proto_err_q <= 1'b1;
      end
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (any_run) proto_err_q <= 1'b1;
        end
        ST_ARMED, ST_COMPRESS: begin
          if (bus.finish) begin
            state_q <= ST_CHECK;
            if (bus.running) proto_err_q <= 1'b1;
          end else if (bus.running) begin
            state_q <= ST_COMPRESS;
            if (count_q != CNT_MAX) count_q <= count_q + 1'b1;
          end
        end
        ST_CHECK: begin
          done_q  <= 1'b1;
          pass_q  <= match;
          fail_q  <= !match;
          state_q <= ST_DONE;
          // The run has ended; further run strobes break the protocol.
          if (any_run) proto_err_q <= 1'b1;
        end
        ST_DONE: begin
          if (any_run) proto_err_q <= 1'b1;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.signature = sig_q;
  assign bus.count     = count_q;
  assign bus.done      = done_q;
  assign bus.pass      = pass_q;
  assign bus.fail      = fail_q;
  assign bus.proto_err = proto_err_q;
  assign bus.state     = state_q;

endmodule

// File: tb/tb_bist_response_analyzer.sv
// Testbench for bist_response_analyzer: directed protocol scenarios followed
// by randomized legal runs checked against a GF(2) polynomial reference.
module tb_bist_response_analyzer;
  import bist_pkg::*;

  localparam int         W       = 8;
  localparam int         CW      = 4;
  localparam logic [7:0] GOLD    = 8'h1D;
  localparam int         EXP_CYC = 2;
  localparam logic [8:0] POLY9   = 9'h11D;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  bist_response_analyzer_if #(.WIDTH(W), .CNT_W(CW)) bus ();

  bist_response_analyzer #(
    .WIDTH      (W),
    .POLY       (8'h1D),
    .SEED       (8'h00),
    .GOLDEN     (GOLD),
    .EXP_CYCLES (EXP_CYC),
    .CNT_W      (CW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  // ---------------- reference model ----------------
  // Signature update as polynomial arithmetic: multiply by x modulo
  // x^8+x^4+x^3+x^2+1, then add the response word.
  function automatic logic [7:0] misr_ref(input logic [7:0] s, input logic [7:0] d);
    logic [8:0] t;
    t = {s, 1'b0};
    if (t[8]) t = t ^ POLY9;
    return t[7:0] ^ d;
  endfunction

  // ---------------- scoreboard check ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Drive strobes for one cycle; return #1 after the capturing edge.
  task automatic step(input logic i, input logic r, input logic f, input logic [7:0] d);
    bus.init    = i;
    bus.running = r;
    bus.finish  = f;
    bus.data_in = d;
    @(posedge clk);
    #1;
    bus.init    = 1'b0;
    bus.running = 1'b0;
    bus.finish  = 1'b0;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    repeat (n) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic chk_result(input string tag, input logic p);
    chk({tag, "_done"}, bus.done, 1);
    chk({tag, "_pass"}, bus.pass, p);
    chk({tag, "_fail"}, bus.fail, !p);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bus.start   = 1'b0;
    bus.init    = 1'b0;
    bus.running = 1'b0;
    bus.finish  = 1'b0;
    bus.data_in = '0;
    reset       = 1'b0;

    // Reset state
    do_reset(2);
    chk("rst_sig", bus.signature, 8'h00);
    chk("rst_cnt", bus.count, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_pass", bus.pass, 0);
    chk("rst_fail", bus.fail, 0);
    chk("rst_perr", bus.proto_err, 0);

    // Passing run: 0x80, 0x00 -> 0x1D, count 2
    step(1, 0, 0, 8'h00);
    step(0, 1, 0, 8'h80);
    chk("pass_sig1", bus.signature, 8'h80);
    chk("pass_cnt1", bus.count, 1);
    step(0, 1, 0, 8'h00);
    chk("pass_sig2", bus.signature, 8'h1D);
    chk("pass_cnt2", bus.count, 2);
    step(0, 0, 1, 8'h00);
    chk("pass_check_done", bus.done, 0);
    step(0, 0, 0, 8'h00);
    chk_result("pass", 1'b1);
    chk("pass_perr", bus.proto_err, 0);
    step(0, 0, 0, 8'h00);
    chk("pass_hold", bus.pass, 1);

    // Signature fail: 0x80, 0x01 -> 0x1C (init from DONE is legal)
    step(1, 0, 0, 8'h00);
    chk("sfail_init_done", bus.done, 0);
    chk("sfail_init_pass", bus.pass, 0);
    step(0, 1, 0, 8'h80);
    step(0, 1, 0, 8'h01);
    chk("sfail_sig", bus.signature, 8'h1C);
    step(0, 0, 1, 8'h00);
    step(0, 0, 0, 8'h00);
    chk_result("sfail", 1'b0);

    // Count fail: signature matches golden but three responses were absorbed
    step(1, 0, 0, 8'h00);
    step(0, 1, 0, 8'h00);
    step(0, 1, 0, 8'h80);
    step(0, 1, 0, 8'h00);
    chk("cfail_sig", bus.signature, 8'h1D);
    chk("cfail_cnt", bus.count, 3);
    step(0, 0, 1, 8'h00);
    step(0, 0, 0, 8'h00);
    chk_result("cfail", 1'b0);
    chk("cfail_perr", bus.proto_err, 0);

    // Protocol error: running while IDLE
    pulse_start();
    chk("start_done", bus.done, 0);
    chk("start_fail", bus.fail, 0);
    step(0, 1, 0, 8'h55);
    chk("idle_run_perr", bus.proto_err, 1);
    chk("idle_run_sig", bus.signature, 8'h00);
    chk("idle_run_cnt", bus.count, 0);
    pulse_start();
    chk("start_clr_perr", bus.proto_err, 0);

    // Reset in the middle of a run
    step(1, 0, 0, 8'h00);
    step(0, 1, 0, 8'h12);
    step(0, 1, 0, 8'h34);
    chk("mid_cnt_pre", bus.count, 2);
    chk("mid_sig_pre", bus.signature, misr_ref(misr_ref(8'h00, 8'h12), 8'h34));
    do_reset(1);
    chk("mid_cnt", bus.count, 0);
    chk("mid_sig", bus.signature, 8'h00);
    step(0, 0, 1, 8'h00);
    chk("mid_fin_perr", bus.proto_err, 1);
    chk("mid_fin_done", bus.done, 0);
    step(0, 0, 0, 8'h00);
    chk("mid_fin_done2", bus.done, 0);

    // init together with running in IDLE: init wins, error flagged
    pulse_start();
    step(1, 1, 0, 8'hAA);
    chk("init_run_perr", bus.proto_err, 1);
    chk("init_run_sig", bus.signature, 8'h00);
    chk("init_run_cnt", bus.count, 0);
    chk("init_run_state", bus.state, ST_ARMED);

    // running with finish in COMPRESS: finish wins, no absorb
    pulse_start();
    step(1, 0, 0, 8'h00);
    step(0, 1, 0, 8'h42);
    chk("rf_sig_pre", bus.signature, 8'h42);
    chk("rf_perr_pre", bus.proto_err, 0);
    step(0, 1, 1, 8'hFF);
    chk("rf_sig", bus.signature, 8'h42);
    chk("rf_cnt", bus.count, 1);
    chk("rf_perr", bus.proto_err, 1);
    step(0, 0, 0, 8'h00);
    chk_result("rf", 1'b0);

    // init inside COMPRESS: reload seed, flag error
    pulse_start();
    step(1, 0, 0, 8'h00);
    step(0, 1, 0, 8'h99);
    step(1, 0, 0, 8'h00);
    chk("reinit_sig", bus.signature, 8'h00);
    chk("reinit_cnt", bus.count, 0);
    chk("reinit_perr", bus.proto_err, 1);

    // Randomized legal runs (lengths cover count saturation)
    for (int r = 0; r < 10; r++) begin
      int n;
      int ref_cnt;
      logic [7:0] ref_sig;
      logic [7:0] d;
      logic exp_pass;
      n = (r == 0) ? 20 : int'($urandom_range(0, 20));
      ref_cnt = 0;
      ref_sig = 8'h00;
      pulse_start();
      step(1, 0, 0, 8'h00);
      for (int k = 0; k < n; k++) begin
        if ($urandom_range(0, 3) == 0) begin
          step(0, 0, 0, 8'($urandom));
          chk("rnd_gap_sig", bus.signature, ref_sig);
        end
        d = 8'($urandom);
        ref_sig = misr_ref(ref_sig, d);
        if (ref_cnt < (1 << CW) - 1) ref_cnt++;
        exp_q.push_back(ref_sig);
        step(0, 1, 0, d);
        chk("rnd_sig", bus.signature, exp_q.pop_front());
      end
      chk("rnd_cnt", bus.count, ref_cnt);
      exp_pass = (ref_sig == GOLD) && (ref_cnt == EXP_CYC);
      step(0, 0, 1, 8'h00);
      step(0, 0, 0, 8'h00);
      chk_result("rnd", exp_pass);
      chk("rnd_perr", bus.proto_err, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
